// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: reads 16-bit halfwords, detects the instruction length
// from bit 15 and presents one assembled 32-bit word per valid/ready handshake.
module fetch_aligner #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     fetchoutput,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_len32,
  output logic            fetch_valid,
  input  logic            fetch_ready
);

  typedef enum logic [2:0] {
    FIRST,
    FIRST_WAIT,
    SECOND,
    SECOND_WAIT,
    OUT,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     hw0_q, hw0_d;
  logic [31:0]     fetchoutput_q, fetchoutput_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            fetch_len32_q, fetch_len32_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FIRST;
      pc_q          <= RESET_PC;
      hw0_q         <= '0;
      fetchoutput_q <= '0;
      fetch_pc_q    <= '0;
      fetch_len32_q <= 1'b0;
      fetch_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hw0_q         <= hw0_d;
      fetchoutput_q <= fetchoutput_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_len32_q <= fetch_len32_d;
      fetch_valid_q <= fetch_valid_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hw0_d         = hw0_q;
    fetchoutput_d = fetchoutput_q;
    fetch_len32_d = fetch_len32_q;

    // FIRST/SECOND only advance once their request has actually been on the bus;
    // right after reset FIRST spends one cycle raising the request.
    case (state_q)
      FIRST: begin
        if (imem_req_q) state_d = FIRST_WAIT;
      end
      FIRST_WAIT: begin
        if (imem_rvalid) begin
          hw0_d = imem_rdata;
          if (imem_rdata[15]) begin
            state_d = SECOND;
          end else begin
            fetchoutput_d = {imem_rdata, 16'h0000};
            fetch_len32_d = 1'b0;
            state_d       = OUT;
          end
        end
      end
      SECOND: begin
        if (imem_req_q) state_d = SECOND_WAIT;
      end
      SECOND_WAIT: begin
        if (imem_rvalid) begin
          fetchoutput_d = {hw0_q, imem_rdata};
          fetch_len32_d = 1'b1;
          state_d       = OUT;
        end
      end
      OUT: begin
        if (fetch_ready) begin
          pc_d    = pc_q + (fetch_len32_q ? PC_W'(2) : PC_W'(1));
          state_d = FIRST;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FIRST;
      end
      default: state_d = FIRST;
    endcase

    // Redirect wins; a read still in flight must be drained before refetching.
    if (redirect) begin
      pc_d          = redirect_pc;
      hw0_d         = hw0_q;
      fetchoutput_d = fetchoutput_q;
      fetch_len32_d = fetch_len32_q;
      if (imem_req_q ||
          (((state_q == FIRST_WAIT) || (state_q == SECOND_WAIT) || (state_q == DRAIN)) &&
           !imem_rvalid)) begin
        state_d = DRAIN;
      end else begin
        state_d = FIRST;
      end
    end
  end

  always_comb begin
    fetch_valid_d = (state_d == OUT);
    fetch_pc_d    = fetch_valid_d ? pc_d : fetch_pc_q;
    imem_req_d    = (state_d == FIRST) || (state_d == SECOND);
    imem_addr_d   = imem_addr_q;
    if (state_d == FIRST) begin
      imem_addr_d = pc_d;
    end else if (state_d == SECOND) begin
      imem_addr_d = pc_d + PC_W'(1);
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign fetchoutput = fetchoutput_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_len32 = fetch_len32_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an instruction-level model.
module tb_fetch_aligner;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [15:0]     imem_rdata;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     fetchoutput;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_len32;
  logic            fetch_valid;
  logic            fetch_ready;

  logic [15:0] mem [0:65535];

  int n_cmp        = 0;
  int n_fail       = 0;
  int cycle        = 0;
  int lat_min      = 1;
  int lat_max      = 1;
  bit spurious_en  = 1'b0;
  int accepted_cnt = 0;

  fetch_aligner #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetchoutput (fetchoutput),
    .fetch_pc    (fetch_pc),
    .fetch_len32 (fetch_len32),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // An instruction is defined purely by the memory image and its start address.
  function automatic logic [31:0] exp_word(input logic [15:0] p);
    logic [15:0] p1;
    p1 = p + 16'd1;
    return mem[p][15] ? {mem[p], mem[p1]} : {mem[p], 16'h0000};
  endfunction

  // Memory: one read at a time, response after a configurable latency, with
  // optional junk rvalid pulses while an instruction is being held.
  initial begin
    bit          pending;
    logic [15:0] paddr;
    int          cnt;
    pending     = 1'b0;
    paddr       = '0;
    cnt         = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (rst_n && imem_req) checkOutput("req_while_outstanding", 32'(pending), 32'd0);
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[paddr];
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spurious_en && fetch_valid && ($urandom_range(0, 7) == 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 16'($urandom);
      end
      if (rst_n && imem_req) begin
        pending = 1'b1;
        paddr   = imem_addr;
        cnt     = int'($urandom_range(lat_min, lat_max)) - 1;
      end
    end
  end

  // Instruction-level reference: tracks which instruction must be in flight,
  // which addresses it must read, and what the decoder must be shown.
  initial begin
    logic [15:0] exp_pc;
    int          req_cnt;
    int          need;
    bit          held;
    int          idle;
    exp_pc  = '0;
    req_cnt = 0;
    held    = 1'b0;
    idle    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        checkOutput("rst_imem_req",    32'(imem_req),    32'd0);
        checkOutput("rst_fetchoutput", fetchoutput,      32'd0);
        checkOutput("rst_fetch_pc",    32'(fetch_pc),    32'd0);
        checkOutput("rst_fetch_len32", 32'(fetch_len32), 32'd0);
        checkOutput("rst_imem_addr",   32'(imem_addr),   32'd0);
        exp_pc  = 16'h0000;
        req_cnt = 0;
        held    = 1'b0;
        idle    = 0;
      end else begin
        need = mem[exp_pc][15] ? 2 : 1;
        if (imem_req) begin
          checkOutput("req_during_out", 32'(fetch_valid), 32'd0);
          if (req_cnt >= need) begin
            checkOutput("extra_req_count", 32'(req_cnt + 1), 32'(need));
          end else begin
            checkOutput("req_addr", 32'(imem_addr), 32'(16'(exp_pc + 16'(req_cnt))));
          end
          req_cnt++;
        end
        if (held) checkOutput("valid_held", 32'(fetch_valid), 32'd1);
        if (fetch_valid) begin
          checkOutput("model_word",  fetchoutput,      exp_word(exp_pc));
          checkOutput("model_pc",    32'(fetch_pc),    32'(exp_pc));
          checkOutput("model_len32", 32'(fetch_len32), 32'(need == 2));
          checkOutput("model_reads", 32'(req_cnt),     32'(need));
        end
        if (redirect) begin
          exp_pc  = redirect_pc;
          req_cnt = 0;
          held    = 1'b0;
          idle    = 0;
        end else if (fetch_valid && fetch_ready) begin
          exp_pc  = exp_pc + 16'(need);
          req_cnt = 0;
          held    = 1'b0;
          idle    = 0;
          accepted_cnt++;
        end else begin
          held = fetch_valid;
          if (!fetch_valid) idle++;
          if (idle >= 40) begin
            checkOutput("progress_timeout", 32'(idle), 32'd0);
            idle = 0;
          end
        end
      end
    end
  end

  task automatic waitReq(input string tag, output logic [15:0] addr, output int cyc);
    bit found;
    found = 1'b0;
    addr  = '0;
    cyc   = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        addr  = imem_addr;
        cyc   = cycle;
      end
    end
    if (!found) checkOutput({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitValid(input string tag, output int cyc);
    bit found;
    found = 1'b0;
    cyc   = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (fetch_valid) begin
        found = 1'b1;
        cyc   = cycle;
      end
    end
    if (!found) checkOutput({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulseReady();
    @(posedge clk); #1;
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
  endtask

  task automatic doRedirect(input logic [15:0] target, output int cyc);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = target;
    cyc         = cycle;
    @(posedge clk); #1;
    redirect    = 1'b0;
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1;
    fetch_ready = ($urandom_range(0, 3) != 0);
    redirect    = ($urandom_range(0, 29) == 0);
    if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFF - 16'($urandom_range(0, 3));
    else                           redirect_pc = 16'($urandom);
  endtask

  initial begin
    logic [15:0] a;
    int          c0, c1, cv, cr, acc0;
    logic [31:0] w_hold;
    logic [15:0] pc_hold;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h0001;
    mem[16'h0004] = 16'h8A01;
    mem[16'h0005] = 16'h8003;
    mem[16'h0006] = 16'h8555;
    mem[16'h0007] = 16'h7777;
    mem[16'h0100] = 16'h4321;
    mem[16'h0200] = 16'h9000;
    mem[16'h0201] = 16'h1111;
    mem[16'hFFFF] = 16'h8123;

    rst_n       = 1'b1;
    fetch_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release: 16-bit instruction at address 0.
    waitReq("t1", a, c0);
    checkOutput("t1_first_addr", 32'(a), 32'h0000);
    waitValid("t1", cv);
    checkOutput("t1_word",    fetchoutput,      32'h12340000);
    checkOutput("t1_len32",   32'(fetch_len32), 32'd0);
    checkOutput("t1_pc",      32'(fetch_pc),    32'h0000);
    checkOutput("t1_latency", 32'(cv - c0),     32'd2);
    pulseReady();
    waitReq("t1_next", a, c1);
    checkOutput("t1_next_addr", 32'(a), 32'h0001);

    // Redirect to 4 while holding, with ready high in the same cycle.
    waitValid("t2_pre", cv);
    @(posedge clk); #1;
    fetch_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0004;
    @(posedge clk); #1;
    redirect    = 1'b0;
    fetch_ready = 1'b0;
    waitReq("t2_a", a, c0);
    checkOutput("t2_addr_first", 32'(a), 32'h0004);
    waitReq("t2_b", a, c1);
    checkOutput("t2_addr_second", 32'(a), 32'h0005);
    waitValid("t2", cv);
    checkOutput("t2_word",    fetchoutput,      32'h8A018003);
    checkOutput("t2_len32",   32'(fetch_len32), 32'd1);
    checkOutput("t2_pc",      32'(fetch_pc),    32'h0004);
    checkOutput("t2_latency", 32'(cv - c0),     32'd4);

    // Decoder stalls for five cycles: everything must hold, no new reads.
    w_hold  = fetchoutput;
    pc_hold = fetch_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3_valid",  32'(fetch_valid), 32'd1);
      checkOutput("t3_word",   fetchoutput,      w_hold);
      checkOutput("t3_pc",     32'(fetch_pc),    32'(pc_hold));
      checkOutput("t3_no_req", 32'(imem_req),    32'd0);
    end
    lat_min = 3;
    lat_max = 3;
    acc0    = accepted_cnt;
    pulseReady();
    waitReq("t3_next", a, c0);
    checkOutput("t3_next_addr", 32'(a), 32'h0006);
    checkOutput("t3_accepts",   32'(accepted_cnt - acc0), 32'd1);

    // Redirect while the second halfword read is outstanding.
    waitReq("t4_second", a, c0);
    checkOutput("t4_second_addr", 32'(a), 32'h0007);
    doRedirect(16'h0100, cr);
    waitReq("t4_after", a, c1);
    checkOutput("t4_redirect_addr", 32'(a), 32'h0100);
    checkOutput("t4_drain_gap",     32'(c1 - cr), 32'd3);
    waitValid("t4", cv);
    checkOutput("t4_word",     fetchoutput,   32'h43210000);
    checkOutput("t4_pc",       32'(fetch_pc), 32'h0100);
    checkOutput("t4_no_stale", 32'(fetchoutput == 32'h85557777), 32'd0);

    // 32-bit instruction straddling the top of the address space.
    lat_min = 1;
    lat_max = 1;
    doRedirect(16'hFFFF, cr);
    waitReq("t5_a", a, c0);
    checkOutput("t5_addr_first", 32'(a), 32'hFFFF);
    waitReq("t5_b", a, c1);
    checkOutput("t5_addr_wrap", 32'(a), 32'h0000);
    waitValid("t5", cv);
    checkOutput("t5_word",  fetchoutput,      32'h81231234);
    checkOutput("t5_pc",    32'(fetch_pc),    32'hFFFF);
    checkOutput("t5_len32", 32'(fetch_len32), 32'd1);
    pulseReady();
    waitReq("t5_next", a, c0);
    checkOutput("t5_next_addr", 32'(a), 32'h0001);

    // Reset in the middle of the second read; the late response must be ignored.
    waitValid("t6_pre", cv);
    lat_min = 3;
    lat_max = 3;
    doRedirect(16'h0200, cr);
    waitReq("t6_a", a, c0);
    checkOutput("t6_addr_first", 32'(a), 32'h0200);
    waitReq("t6_b", a, c1);
    checkOutput("t6_addr_second", 32'(a), 32'h0201);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_valid", 32'(fetch_valid), 32'd0);
    checkOutput("t6_rst_word",  fetchoutput,      32'd0);
    checkOutput("t6_rst_req",   32'(imem_req),    32'd0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    waitReq("t6_restart", a, c0);
    checkOutput("t6_restart_addr", 32'(a), 32'h0000);
    waitValid("t6", cv);
    checkOutput("t6_word", fetchoutput, 32'h12340000);

    // Randomized traffic: variable latency, stalls, redirects and junk rvalid.
    lat_min     = 1;
    lat_max     = 4;
    spurious_en = 1'b1;
    acc0        = accepted_cnt;
    repeat (3000) applyStimulus();
    @(posedge clk); #1;
    redirect    = 1'b0;
    fetch_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("random_progress", 32'(accepted_cnt - acc0 > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Front-end instruction fetch unit that drives the decoder's 32-bit instruction input.
- Reads 16-bit halfwords from program memory and determines instruction length from halfword bit 15.
- Assembles each instruction into the 32-bit word format the decoder consumes:
  - 16-bit instruction → {hw, 16'h0000}, with bit 31 = 0.
  - 32-bit instruction → {hw_first, hw_second}, with bit 31 = 1.
- Presents one instruction at a time over a valid/ready handshake and supports redirect (branch/flush).

Parameters:
- PC_W, 16, width of halfword program address; wraps modulo 2^PC_W.
- RESET_PC, 0, halfword address fetched first after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  read request to program memory, one-cycle pulse
- imem_addr  output  PC_W  halfword address of request, valid while imem_req=1
- imem_rvalid  input  1  read data valid; arrives any cycle ≥1 after imem_req, at most one outstanding
- imem_rdata  input  16  read halfword, valid when imem_rvalid=1
- redirect  input  1  discard current instruction and restart fetch at redirect_pc
- redirect_pc  input  PC_W  new fetch address, sampled when redirect=1
- fetchoutput  output  32  assembled instruction word to decoder
- fetch_pc  output  PC_W  halfword address of first halfword of fetchoutput
- fetch_len32  output  1  1 = fetchoutput is a 32-bit instruction
- fetch_valid  output  1  fetchoutput/fetch_pc/fetch_len32 valid
- fetch_ready  input  1  decoder accepts instruction when fetch_valid & fetch_ready

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=FIRST, pc=RESET_PC, hw0=0, fetchoutput=0, fetch_pc=0, fetch_len32=0, fetch_valid=0, imem_req=0, imem_addr=0.
  - Effect is immediate and overrides any state, including an outstanding memory read, which is forgotten.
- States: FIRST, FIRST_WAIT, SECOND, SECOND_WAIT, OUT, DRAIN. All outputs are registered.
- FIRST:
  - imem_req=1, imem_addr=pc.
  - → FIRST_WAIT.
- FIRST_WAIT: on imem_rvalid, hw0<=imem_rdata, then:
  - rdata[15]=0 → fetchoutput<={rdata,16'h0}, fetch_len32<=0, → OUT.
  - rdata[15]=1 → SECOND.
- SECOND:
  - imem_req=1, imem_addr=pc+1 (mod 2^PC_W).
  - → SECOND_WAIT.
- SECOND_WAIT: on imem_rvalid:
  - fetchoutput<={hw0,imem_rdata}, fetch_len32<=1, → OUT.
  - Bit 15 of the second halfword is passed through unchecked.
- OUT:
  - fetch_valid=1, fetch_pc=pc; outputs held stable until accepted.
  - On fetch_ready: pc<=pc+1 (16-bit) or pc+2 (32-bit), mod 2^PC_W, → FIRST.
- Latency with 1-cycle memory:
  - 16-bit instruction: fetch_valid rises 2 cycles after FIRST entry.
  - 32-bit instruction: fetch_valid rises 4 cycles after FIRST entry.
  - Back-to-back 16-bit instructions under constant fetch_ready: one accepted every 3 cycles.
- Redirect (has priority over every other transition in the same cycle):
  - pc<=redirect_pc, fetch_valid<=0; the held instruction is not accepted even if fetch_ready=1.
  - From FIRST_WAIT/SECOND_WAIT with imem_rvalid=0 (read outstanding) → DRAIN.
  - From any other state, or with imem_rvalid=1 that cycle (data discarded) → FIRST.
  - A request issued in FIRST/SECOND in the redirect cycle is still outstanding → DRAIN.
- DRAIN:
  - Wait for imem_rvalid, discard data, → FIRST.
  - A new redirect in DRAIN updates pc and stays in DRAIN.
- Wrap-around: pc=2^PC_W-1 with a 32-bit instruction fetches its second halfword at address 0; next pc=1.
- imem_req is never asserted while a read is outstanding.
- Spurious imem_rvalid in FIRST, SECOND or OUT is ignored.

Test Plan:
- Reset release, mem[0]=16'h1234 (bit15=0), fetch_ready=1 → imem_addr=0; fetchoutput=32'h12340000, fetch_len32=0, fetch_pc=0; next imem_addr=1.
- mem[4]=16'h8A01, mem[5]=16'h8003, start pc=4 → requests to 4 then 5; fetchoutput=32'h8A018003, fetch_len32=1, fetch_pc=4; next request to 6.
- fetch_ready=0 for 5 cycles during OUT → fetch_valid, fetchoutput, fetch_pc stable all 5 cycles; no imem_req; single acceptance on ready.
- Redirect to 16'h0100 in SECOND_WAIT, memory response delayed 3 cycles → DRAIN; stale halfword never appears on fetchoutput; next imem_addr=16'h0100.
- PC_W=16, pc=16'hFFFF, 32-bit instruction → second request address 16'h0000; after acceptance next fetch at 16'h0001.
- rst_n low mid SECOND_WAIT, then response arrives → all outputs 0 immediately; fetch restarts at RESET_PC once rst_n is high.
